// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku loader and solver.
package sudoku_pkg;

  localparam int unsigned GRID_N    = 9;
  localparam int unsigned CELL_W    = 4;
  localparam int unsigned NUM_CELLS = GRID_N * GRID_N;
  localparam int unsigned RC_W      = 4;
  localparam int unsigned CLUE_W    = 7;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_t;

  // Digit 1..9 is a clue
  function automatic logic is_clue(input cell_t d);
    return (d != cell_t'(0)) && (d <= cell_t'(9));
  endfunction

  // Digit 10..15 is illegal
  function automatic logic is_illegal(input cell_t d);
    return d > cell_t'(9);
  endfunction

endpackage

// File: rtl/sudoku_grid_loader_rc_counter.sv
// Row/column write-position counter, row-major over a 9x9 grid.
module sudoku_rc_counter
  import sudoku_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic            inc,
  input  logic            clr,
  input  logic            sof_load,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last
);

  localparam logic [RC_W-1:0] LAST_IDX = RC_W'(GRID_N - 1);

  logic [RC_W-1:0] r_row;
  logic [RC_W-1:0] r_col;
  logic            r_last;
  logic [RC_W-1:0] w_row_nxt;
  logic [RC_W-1:0] w_col_nxt;

  // Next position: clear beats a frame restart, which beats a plain advance
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (clr) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (sof_load) begin
      w_row_nxt = '0;
      w_col_nxt = RC_W'(1);
    end else if (inc) begin
      if (r_col == LAST_IDX) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == LAST_IDX) ? '0 : r_row + RC_W'(1);
      end else begin
        w_col_nxt = r_col + RC_W'(1);
      end
    end
  end

  // Position registers; last is registered alongside the position it describes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_row  <= '0;
      r_col  <= '0;
      r_last <= 1'b0;
    end else begin
      r_row  <= w_row_nxt;
      r_col  <= w_col_nxt;
      r_last <= (w_row_nxt == LAST_IDX) && (w_col_nxt == LAST_IDX);
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = r_last;

endmodule

// File: rtl/sudoku_grid_loader.sv
// Assembles a row-major cell stream into a held 9x9 grid with clue count and error flag.
module sudoku_grid_loader #(
  parameter int unsigned GRID_N = 9,
  parameter int unsigned CELL_W = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_b,
  input  logic                                         cell_valid,
  input  logic [CELL_W-1:0]                            cell_data,
  input  logic                                         cell_sof,
  output logic                                         cell_ready,
  output logic [GRID_N-1:0][GRID_N-1:0][CELL_W-1:0]    grid,
  output logic                                         grid_valid,
  input  logic                                         grid_ack,
  output logic                                         grid_err,
  output logic [6:0]                                   clue_count
);

  localparam int unsigned RC_W   = sudoku_pkg::RC_W;
  localparam int unsigned CLUE_W = sudoku_pkg::CLUE_W;

  sudoku_pkg::loader_state_t r_state;
  sudoku_pkg::grid_t         r_grid;
  logic                      r_cell_ready;
  logic                      r_grid_valid;
  logic                      r_grid_err;
  logic [CLUE_W-1:0]         r_clue_count;

  logic                      w_accept;
  logic                      w_clr;
  logic                      w_frame_done;
  logic                      w_is_clue;
  logic                      w_is_illegal;
  logic [RC_W-1:0]           w_row;
  logic [RC_W-1:0]           w_col;
  logic                      w_last;
  logic [RC_W-1:0]           w_wr_row;
  logic [RC_W-1:0]           w_wr_col;
  sudoku_pkg::cell_t         w_wr_data;

  assign w_accept     = cell_valid && r_cell_ready;
  assign w_clr        = (r_state == sudoku_pkg::FULL) && grid_ack;
  assign w_frame_done = w_accept && !cell_sof && w_last;
  assign w_is_clue    = sudoku_pkg::is_clue(cell_data);
  assign w_is_illegal = sudoku_pkg::is_illegal(cell_data);
  assign w_wr_row     = cell_sof ? '0 : w_row;
  assign w_wr_col     = cell_sof ? '0 : w_col;
  assign w_wr_data    = w_is_illegal ? '0 : cell_data;

  sudoku_rc_counter u_rc (
    .clk      (clk),
    .rst_b    (rst_b),
    .inc      (w_accept && !cell_sof),
    .clr      (w_clr),
    .sof_load (w_accept && cell_sof),
    .row      (w_row),
    .col      (w_col),
    .last     (w_last)
  );

  // Frame FSM; ready is held low for the first LOAD cycle out of reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= sudoku_pkg::IDLE;
      r_cell_ready <= 1'b0;
      r_grid_valid <= 1'b0;
    end else begin
      case (r_state)
        sudoku_pkg::IDLE: begin
          r_state      <= sudoku_pkg::LOAD;
          r_cell_ready <= 1'b0;
          r_grid_valid <= 1'b0;
        end
        sudoku_pkg::LOAD: begin
          if (w_frame_done) begin
            r_state      <= sudoku_pkg::FULL;
            r_cell_ready <= 1'b0;
            r_grid_valid <= 1'b1;
          end else begin
            r_cell_ready <= 1'b1;
            r_grid_valid <= 1'b0;
          end
        end
        sudoku_pkg::FULL: begin
          if (grid_ack) begin
            r_state      <= sudoku_pkg::LOAD;
            r_cell_ready <= 1'b1;
            r_grid_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= sudoku_pkg::IDLE;
          r_cell_ready <= 1'b0;
          r_grid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-frame clue count and sticky illegal-digit flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_clue_count <= '0;
      r_grid_err   <= 1'b0;
    end else if (w_clr) begin
      r_clue_count <= '0;
      r_grid_err   <= 1'b0;
    end else if (w_accept) begin
      if (cell_sof) begin
        r_clue_count <= CLUE_W'(w_is_clue);
        r_grid_err   <= w_is_illegal;
      end else begin
        r_clue_count <= r_clue_count + CLUE_W'(w_is_clue);
        r_grid_err   <= r_grid_err | w_is_illegal;
      end
    end
  end

  // Grid storage; illegal digits land as empty cells
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_grid <= '0;
    end else if (w_accept) begin
      r_grid[w_wr_row][w_wr_col] <= w_wr_data;
    end
  end

  assign cell_ready = r_cell_ready;
  assign grid_valid = r_grid_valid;
  assign grid_err   = r_grid_err;
  assign clue_count = r_clue_count;
  assign grid       = r_grid;

endmodule

// File: tb/tb_sudoku_grid_loader.sv
// Randomized bench for sudoku_grid_loader against a frame-level reference model.
module tb_sudoku_grid_loader;
  import sudoku_pkg::*;

  localparam int unsigned GW = NUM_CELLS * CELL_W;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cell_valid = 1'b0;
  logic [3:0]  cell_data = '0;
  logic        cell_sof = 1'b0;
  logic        grid_ack = 1'b0;
  logic        cell_ready;
  grid_t       grid;
  logic        grid_valid;
  logic        grid_err;
  logic [6:0]  clue_count;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  // Reference model: flat cell image, write index, and values accepted this frame
  cell_t       m_grid [NUM_CELLS];
  int          m_pos = 0;
  int          m_frame [$];
  cell_t       frm [NUM_CELLS];

  sudoku_grid_loader dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cell_valid (cell_valid),
    .cell_data  (cell_data),
    .cell_sof   (cell_sof),
    .cell_ready (cell_ready),
    .grid       (grid),
    .grid_valid (grid_valid),
    .grid_ack   (grid_ack),
    .grid_err   (grid_err),
    .clue_count (clue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic grid_t m_exp_grid();
    grid_t g;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[r][c] = m_grid[r*9 + c];
    return g;
  endfunction

  function automatic int m_clue();
    int n = 0;
    foreach (m_frame[i]) if (m_frame[i] >= 1 && m_frame[i] <= 9) n++;
    return n;
  endfunction

  function automatic logic m_err();
    foreach (m_frame[i]) if (m_frame[i] > 9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept(input int d, input logic sof);
    if (sof) begin
      m_pos = 0;
      m_frame.delete();
    end
    m_grid[m_pos] = (d > 9) ? cell_t'(0) : cell_t'(d);
    m_pos++;
    m_frame.push_back(d);
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_frame.delete();
    for (int i = 0; i < NUM_CELLS; i++) m_grid[i] = '0;
  endtask

  // Present one cell from a negedge; returns at the negedge after it is accepted
  task automatic send_cell(input int d, input logic sof, input logic gaps);
    int guard = 0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      cell_valid = 1'b0;
      @(negedge clk);
    end
    cell_valid = 1'b1;
    cell_data  = 4'(d);
    cell_sof   = sof;
    while (!cell_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cell_ready) begin
      check("ready_timeout", GW'(cell_ready), GW'(1));
      cell_valid = 1'b0;
      return;
    end
    @(negedge clk);
    model_accept(d, sof);
    cell_sof = 1'b0;
    check("valid_track", GW'(grid_valid), GW'(m_pos == NUM_CELLS));
  endtask

  task automatic send_frame(input logic gaps);
    for (int i = 0; i < NUM_CELLS; i++) send_cell(int'(frm[i]), 1'b0, gaps);
    cell_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_valid"}, GW'(grid_valid), GW'(1));
    check({tag, "_grid"}, GW'(grid), GW'(m_exp_grid()));
    check({tag, "_clue"}, GW'(clue_count), GW'(m_clue()));
    check({tag, "_err"}, GW'(grid_err), GW'(m_err()));
  endtask

  task automatic do_ack();
    cell_valid = 1'b0;
    grid_ack   = 1'b1;
    @(posedge clk);
    #1;
    grid_ack = 1'b0;
    check("ack_valid", GW'(grid_valid), GW'(0));
    check("ack_ready", GW'(cell_ready), GW'(1));
    m_pos = 0;
    m_frame.delete();
    @(negedge clk);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NUM_CELLS; i++) frm[i] = cell_t'($urandom_range(0, 9));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, GW'(cell_ready), GW'(0));
    check({tag, "_valid"}, GW'(grid_valid), GW'(0));
    check({tag, "_err"}, GW'(grid_err), GW'(0));
    check({tag, "_clue"}, GW'(clue_count), GW'(0));
    check({tag, "_grid"}, GW'(grid), GW'(0));
  endtask

  initial begin
    grid_t held;
    model_reset();

    // Reset state and ready timing after release
    repeat (2) @(negedge clk);
    check_reset_outs("rst");
    rst_b = 1'b1;
    @(posedge clk);
    #1 check("ready_edge1", GW'(cell_ready), GW'(0));
    @(posedge clk);
    #1 check("ready_edge2", GW'(cell_ready), GW'(1));
    @(negedge clk);

    // Known puzzle: four clues per row, 36 in total
    for (int i = 0; i < NUM_CELLS; i++)
      frm[i] = (i % 9 < 4) ? cell_t'(((i * 7 + i / 9) % 9) + 1) : cell_t'(0);
    send_frame(1'b0);
    check_frame("puzzle");
    check("puzzle_clue36", GW'(clue_count), GW'(36));
    do_ack();

    // Same puzzle with random valid gaps
    send_frame(1'b1);
    check_frame("gaps");
    check("gaps_clue36", GW'(clue_count), GW'(36));
    do_ack();

    // Illegal digit at [3][4]
    rand_frame();
    frm[31] = cell_t'(12);
    send_frame(1'b1);
    check_frame("illegal");
    check("illegal_cell", GW'(grid[3][4]), GW'(0));
    check("illegal_err", GW'(grid_err), GW'(1));
    do_ack();
    rand_frame();
    send_frame(1'b0);
    check_frame("clean");
    check("clean_err", GW'(grid_err), GW'(0));
    do_ack();

    // Frame restart at accept 40
    rand_frame();
    for (int i = 0; i < 39; i++) send_cell(int'(frm[i]), 1'b0, 1'b1);
    send_cell(5, 1'b1, 1'b1);
    rand_frame();
    for (int i = 1; i < NUM_CELLS; i++) send_cell(int'(frm[i]), 1'b0, 1'b1);
    check_frame("sof");
    check("sof_cell00", GW'(grid[0][0]), GW'(5));

    // Held in FULL with valid asserted and no ack
    held       = m_exp_grid();
    cell_valid = 1'b1;
    cell_data  = 4'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("full_ready", GW'(cell_ready), GW'(0));
      check("full_grid", GW'(grid), GW'(held));
    end
    do_ack();

    // Reset at accept 60, then a full frame
    rand_frame();
    for (int i = 0; i < 60; i++) send_cell(int'(frm[i]), 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check_reset_outs("midrst");
    cell_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    rand_frame();
    send_frame(1'b1);
    check_frame("after_rst");
    do_ack();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
